nibble_harvard_memory: RTL and testbench
========================================

NIBBLE_HARVARD_MEMORY -- requirements
Module: nibble_harvard_memory

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port program_counter, input, 5 bits: fetch address from the CPU.
REQ-005 Port instruction, output, 8 bits: the instruction byte returned to the CPU.
REQ-006 Port address_in, input, 4 bits: data-memory address from the CPU.
REQ-007 Port data_in, input, 4 bits: write data from the CPU accumulator.
REQ-008 Port write_to_memory, input, 1 bit: CPU store strobe.
REQ-009 Port data_out, output, 4 bits: read data returned to the CPU.
REQ-010 Port load_data, input, 8 bits: loader byte.
REQ-011 Port load_valid, input, 1 bit: loader byte is valid.
REQ-012 Port load_ready, output, 1 bit: the block accepts a loader byte.
REQ-013 Port reload, input, 1 bit: request to return to program load.
REQ-014 Port cpu_reset, output, 1 bit: active-high reset that drives the CPU.
REQ-015 Port halted, output, 1 bit: the current instruction is HALT.

Function
REQ-016 Storage SHALL be a 32x8 program RAM and a 16x4 data RAM.
REQ-017 instruction SHALL equal prog[program_counter] combinationally, with zero-cycle latency.
REQ-018 data_out SHALL equal data[address_in] combinationally.
REQ-019 halted SHALL equal (instruction[7:4] == 4'b0001), evaluated in every state.
REQ-020 The FSM states SHALL be LOAD_PROG, LOAD_DATA and RUN.
REQ-021 LOAD_PROG SHALL behave as follows:
 - load_ready = 1.
 - On load_valid && load_ready, write prog[cnt] = load_data and increment the 5-bit cnt.
 - When the transfer with cnt == 31 completes, clear cnt and move to LOAD_DATA.
REQ-022 LOAD_DATA SHALL behave as follows:
 - load_ready = 1.
 - Each transfer writes data[2*cnt] = load_data[3:0] and data[2*cnt+1] = load_data[7:4].
 - When the transfer with cnt == 7 completes, move to RUN.
REQ-023 RUN SHALL behave as follows:
 - load_ready = 0; load_valid is ignored.
 - On write_to_memory == 1 at a rising edge, write data[address_in] = data_in.
REQ-024 In LOAD_PROG and LOAD_DATA, write_to_memory SHALL be ignored, since the CPU's STA decode fires during reset.
REQ-025 cpu_reset SHALL be 1 in every state except RUN, and 0 starting the first cycle in RUN.
REQ-026 reload == 1 in RUN SHALL move the FSM to LOAD_PROG with cnt = 0 on the next edge; an in-flight CPU store in that same cycle SHALL still complete.
REQ-027 reload SHALL be ignored in the load states.
REQ-028 Loader stalls, i.e. load_valid == 0 for any number of cycles, SHALL hold state and cnt.
REQ-029 RAM contents SHALL persist across reload and reset; only bytes that are rewritten change.

Reset
REQ-030 reset == 0 at a rising edge SHALL set the following, with RAM untouched:
 - state = LOAD_PROG
 - cnt = 0
 - cpu_reset = 1
 - load_ready = 1
REQ-031 Reset asserted mid-load SHALL abort the load and restart it at program byte 0.
REQ-032 Reset SHALL take priority over reload, load transfers and CPU writes in the same cycle.

Configuration
REQ-033 The data-preload feature SHALL be controlled by the macro NIBBLE_MEM_DATA_PRELOAD_EN.
REQ-034 With NIBBLE_MEM_DATA_PRELOAD_EN defined, the LOAD_DATA state SHALL behave as in REQ-022.
REQ-035 With NIBBLE_MEM_DATA_PRELOAD_EN undefined, LOAD_DATA SHALL be replaced by a CLEAR state:
 - load_ready = 0.
 - Write data[cnt[3:0]] = 0 for 16 cycles, then enter RUN.
 - cpu_reset = 1 throughout.

Structure
REQ-036 A shared package SHALL hold:
 - the state enum {LOAD_PROG, LOAD_DATA/CLEAR, RUN};
 - PROG_DEPTH = 32, DATA_DEPTH = 16;
 - OPC_HALT = 4'b0001.
REQ-037 The load FSM and counter SHALL be a sub-module, nibble_mem_loader; the RAM arrays SHALL stay in the top level.

Verification
REQ-038 Program load: stream bytes 8'h00..8'h1F then 8 data bytes 8'h21 -> prog[5] = 8'h05, data[0] = 1, data[1] = 2, and cpu_reset falls on the cycle after byte 40.
REQ-039 Stall: drop load_valid for 10 cycles at byte 12 -> cnt holds at 12, and the load completes with correct contents.
REQ-040 RUN store: address_in = 4'h9, data_in = 4'hC, write_to_memory = 1 for one cycle -> data_out = 4'hC on the next cycle at address 9.
REQ-041 Store during load: write_to_memory = 1 with address_in = 4'h3 while in LOAD_PROG -> data[3] is unchanged.
REQ-042 Reset mid-load: reset = 0 after 20 program bytes -> next accepted byte goes to prog[0]; halted = 1 when program_counter addresses byte 8'h10.
REQ-043 Reload: pulse reload in RUN -> cpu_reset = 1 and load_ready = 1 on the next cycle; with NIBBLE_MEM_DATA_PRELOAD_EN undefined, data reads 0 everywhere 16 cycles after the program load.

Source files
------------

// File: rtl/nibble_harvard_memory_pkg.sv
// Shared types and constants for the nibble Harvard memory.
// NIBBLE_MEM_DATA_PRELOAD_EN selects a loader-fed data phase; otherwise data RAM is cleared.
package nibble_harvard_memory_pkg;

  localparam int PROG_DEPTH = 32;
  localparam int DATA_DEPTH = 16;
  localparam logic [3:0] OPC_HALT = 4'b0001;

`ifdef NIBBLE_MEM_DATA_PRELOAD_EN
  typedef enum logic [1:0] {
    LOAD_PROG = 2'd0,
    LOAD_DATA = 2'd1,
    RUN       = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    LOAD_PROG = 2'd0,
    CLEAR     = 2'd1,
    RUN       = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/nibble_mem_loader.sv
// Load sequencer: streams the program image, then preloads or clears data RAM, then runs the CPU.
// NIBBLE_MEM_DATA_PRELOAD_EN chooses the second phase.
module nibble_mem_loader
  import nibble_harvard_memory_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic       reload,
  output logic       load_ready,
  output logic       cpu_reset,
  output logic       run,
  output logic       prog_we,
  output logic       fill_we,
  output logic [4:0] cnt
);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD_PROG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    run        = 1'b0;
    prog_we    = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      LOAD_PROG: begin
        load_ready = 1'b1;
        if (load_valid) begin
          prog_we = 1'b1;
          if (cnt_q == 5'd31) begin
            cnt_d   = '0;
`ifdef NIBBLE_MEM_DATA_PRELOAD_EN
            state_d = LOAD_DATA;
`else
            state_d = CLEAR;
`endif
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
`ifdef NIBBLE_MEM_DATA_PRELOAD_EN
      LOAD_DATA: begin
        load_ready = 1'b1;
        if (load_valid) begin
          fill_we = 1'b1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
`else
      CLEAR: begin
        fill_we = 1'b1;
        if (cnt_q == 5'd15) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
`endif
      RUN: begin
        cpu_reset = 1'b0;
        run       = 1'b1;
        if (reload) begin
          state_d = LOAD_PROG;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_PROG;
        cnt_d   = '0;
      end
    endcase
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/nibble_harvard_memory.sv
// Harvard memory for a nibble CPU: 32x8 program RAM, 16x4 data RAM, both read combinationally.
// NIBBLE_MEM_DATA_PRELOAD_EN: data RAM is filled from the loader stream instead of cleared.
module nibble_harvard_memory
  import nibble_harvard_memory_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] program_counter,
  output logic [7:0] instruction,
  input  logic [3:0] address_in,
  input  logic [3:0] data_in,
  input  logic       write_to_memory,
  output logic [3:0] data_out,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic       reload,
  output logic       cpu_reset,
  output logic       halted
);

  logic [7:0] prog_mem [PROG_DEPTH];
  logic [3:0] data_mem [DATA_DEPTH];

  logic       run;
  logic       prog_we;
  logic       fill_we;
  logic       cpu_we;
  logic [4:0] cnt;

  nibble_mem_loader u_loader (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .reload     (reload),
    .load_ready (load_ready),
    .cpu_reset  (cpu_reset),
    .run        (run),
    .prog_we    (prog_we),
    .fill_we    (fill_we),
    .cnt        (cnt)
  );

  // CPU stores only land in RUN; the CPU's STA decode can fire while it is held in reset.
  assign cpu_we = run && write_to_memory;

  always_ff @(posedge clk) begin
    if (reset && prog_we) begin
      prog_mem[cnt] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (cpu_we) begin
        data_mem[address_in] <= data_in;
      end
`ifdef NIBBLE_MEM_DATA_PRELOAD_EN
      if (fill_we) begin
        data_mem[{cnt[2:0], 1'b0}] <= load_data[3:0];
        data_mem[{cnt[2:0], 1'b1}] <= load_data[7:4];
      end
`else
      if (fill_we) begin
        data_mem[cnt[3:0]] <= 4'h0;
      end
`endif
    end
  end

  assign instruction = prog_mem[program_counter];
  assign data_out    = data_mem[address_in];
  assign halted      = (instruction[7:4] == OPC_HALT);

endmodule

// File: tb/tb_nibble_harvard_memory.sv
// Self-checking bench for nibble_harvard_memory: load, stall, stores, reload, reset mid-load.
// Honours NIBBLE_MEM_DATA_PRELOAD_EN for the data-phase expectations.
module tb_nibble_harvard_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] program_counter;
  logic [7:0] instruction;
  logic [3:0] address_in;
  logic [3:0] data_in;
  logic       write_to_memory;
  logic [3:0] data_out;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       reload;
  logic       cpu_reset;
  logic       halted;

  int checks = 0;
  int errors = 0;

  logic [3:0] data_model [16];

  typedef struct {
    logic [4:0] pc;
    logic [7:0] exp_instr;
    logic       exp_halted;
    logic [3:0] addr;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
  } store_t;

  vec_t   vecs [6];
  store_t sb [$];

  always #5 clk = ~clk;

  nibble_harvard_memory dut (
    .clk             (clk),
    .reset           (reset),
    .program_counter (program_counter),
    .instruction     (instruction),
    .address_in      (address_in),
    .data_in         (data_in),
    .write_to_memory (write_to_memory),
    .data_out        (data_out),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .reload          (reload),
    .cpu_reset       (cpu_reset),
    .halted          (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  // Second load phase: either 8 preload bytes of 8'h21 or 16 clear cycles.
  task automatic finish_load();
`ifdef NIBBLE_MEM_DATA_PRELOAD_EN
    check("data_phase_ready", load_ready, 1'b1);
    for (int j = 0; j < 8; j++) begin
      check("data_phase_cpu_reset", cpu_reset, 1'b1);
      send_byte(8'h21);
    end
    for (int a = 0; a < 16; a++) data_model[a] = (a % 2 == 0) ? 4'h1 : 4'h2;
`else
    check("clear_ready", load_ready, 1'b0);
    for (int j = 0; j < 16; j++) begin
      check("clear_cpu_reset", cpu_reset, 1'b1);
      tick();
    end
    for (int a = 0; a < 16; a++) data_model[a] = 4'h0;
`endif
    check("run_cpu_reset", cpu_reset, 1'b0);
    check("run_load_ready", load_ready, 1'b0);
  endtask

  initial begin
    store_t s;
    vecs[0] = '{pc: 5'd5,  exp_instr: 8'h05, exp_halted: 1'b0, addr: 4'd0};
    vecs[1] = '{pc: 5'd12, exp_instr: 8'h0C, exp_halted: 1'b0, addr: 4'd1};
    vecs[2] = '{pc: 5'd13, exp_instr: 8'h0D, exp_halted: 1'b0, addr: 4'd9};
    vecs[3] = '{pc: 5'd16, exp_instr: 8'h10, exp_halted: 1'b1, addr: 4'd15};
    vecs[4] = '{pc: 5'd31, exp_instr: 8'h1F, exp_halted: 1'b1, addr: 4'd6};
    vecs[5] = '{pc: 5'd0,  exp_instr: 8'h00, exp_halted: 1'b0, addr: 4'd7};

    reset = 1'b0; program_counter = '0; address_in = '0; data_in = '0;
    write_to_memory = 1'b0; load_data = '0; load_valid = 1'b0; reload = 1'b0;
    tick();
    tick();
    check("reset_cpu_reset", cpu_reset, 1'b1);
    check("reset_load_ready", load_ready, 1'b1);
    reset = 1'b1;

    // Program load with a 10-cycle loader stall at byte 12.
    for (int i = 0; i < 32; i++) begin
      if (i == 12) begin
        for (int k = 0; k < 10; k++) tick();
        check("stall_load_ready", load_ready, 1'b1);
        check("stall_cpu_reset", cpu_reset, 1'b1);
      end
      send_byte(8'(i));
    end
    finish_load();

    for (int v = 0; v < 6; v++) begin
      program_counter = vecs[v].pc;
      address_in      = vecs[v].addr;
      #1;
      check($sformatf("instr_pc%0d", vecs[v].pc), instruction, vecs[v].exp_instr);
      check($sformatf("halted_pc%0d", vecs[v].pc), halted, vecs[v].exp_halted);
      check($sformatf("data_a%0d", vecs[v].addr), data_out, data_model[vecs[v].addr]);
    end

    // Back-to-back RUN stores through the scoreboard.
    s = '{addr: 4'h9, data: 4'hC}; sb.push_back(s);
    s = '{addr: 4'h2, data: 4'h5}; sb.push_back(s);
    s = '{addr: 4'h3, data: 4'hA}; sb.push_back(s);
    s = '{addr: 4'hF, data: 4'h7}; sb.push_back(s);
    foreach (sb[i]) begin
      address_in = sb[i].addr; data_in = sb[i].data; write_to_memory = 1'b1;
      tick();
      data_model[sb[i].addr] = sb[i].data;
    end
    write_to_memory = 1'b0;
    address_in = 4'h9; data_in = 4'h0;
    tick();
    while (sb.size() > 0) begin
      s = sb.pop_front();
      address_in = s.addr;
      #1;
      check($sformatf("store_a%0d", s.addr), data_out, s.data);
    end

    // Reload with a store in the same cycle: the store must still land.
    address_in = 4'h4; data_in = 4'h6; write_to_memory = 1'b1; reload = 1'b1;
    tick();
    write_to_memory = 1'b0; reload = 1'b0;
    data_model[4] = 4'h6;
    check("reload_cpu_reset", cpu_reset, 1'b1);
    check("reload_load_ready", load_ready, 1'b1);
    #1;
    check("reload_store_a4", data_out, data_model[4]);

    // Store strobe during program load is ignored.
    address_in = 4'h3; data_in = 4'hF; write_to_memory = 1'b1;
    tick();
    write_to_memory = 1'b0;
    #1;
    check("load_store_ignored_a3", data_out, data_model[3]);

    // Abort after 20 bytes; reset beats a simultaneous transfer and store.
    for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i));
    reset = 1'b0; load_valid = 1'b1; load_data = 8'hEE; write_to_memory = 1'b1;
    tick();
    reset = 1'b1; load_valid = 1'b0; write_to_memory = 1'b0;
    check("midreset_cpu_reset", cpu_reset, 1'b1);
    check("midreset_load_ready", load_ready, 1'b1);
    program_counter = 5'd20;
    #1;
    check("midreset_prog20_kept", instruction, 8'h14);
    check("midreset_store_blocked", data_out, data_model[3]);

    send_byte(8'hA5);
    program_counter = 5'd0;
    #1;
    check("restart_prog0", instruction, 8'hA5);
    program_counter = 5'd1;
    #1;
    check("restart_prog1_old", instruction, 8'h41);
    for (int i = 1; i < 32; i++) send_byte(8'(i));
    finish_load();

    program_counter = 5'd16;
    #1;
    check("reload_halted_pc16", halted, 1'b1);
    program_counter = 5'd0;
    #1;
    check("reload_instr_pc0", instruction, 8'hA5);
    check("reload_halted_pc0", halted, 1'b0);
    for (int a = 0; a < 16; a++) begin
      address_in = 4'(a);
      #1;
      check($sformatf("post_reload_data_a%0d", a), data_out, data_model[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
